// File: rtl/uart_icb_arbiter_pkg.sv
// rtl/uart_icb_arbiter_pkg.sv - shared state encoding and constants for the UART ICB arbiter
package uart_icb_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CMD  = 2'd1,
    ARB_WAIT = 2'd2,
    ARB_RESP = 2'd3
  } arb_state_t;

  // Read data returned to the requester when a transaction is aborted by the timer
  localparam logic [31:0] ARB_ERR_RDATA = 32'hDEAD_0BAD;

endpackage

// File: rtl/uart_rr_arb2.sv
// rtl/uart_rr_arb2.sv - combinational two-way round-robin picker
module uart_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Contention goes to whoever did not win last time
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/uart_icb_arbiter.sv
// rtl/uart_icb_arbiter.sv - two-requester ICB arbiter with response replay and timeout abort
module uart_icb_arbiter
  import uart_icb_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    m_icb_cmd_valid,
  output logic [1:0]    m_icb_cmd_ready,
  input  logic [2*AW-1:0] m_icb_cmd_addr,
  input  logic [1:0]    m_icb_cmd_read,
  input  logic [2*DW-1:0] m_icb_cmd_wdata,
  output logic [1:0]    m_icb_rsp_valid,
  input  logic [1:0]    m_icb_rsp_ready,
  output logic [DW-1:0] m_icb_rsp_rdata,
  output logic          o_icb_cmd_valid,
  input  logic          o_icb_cmd_ready,
  output logic [AW-1:0] o_icb_cmd_addr,
  output logic          o_icb_cmd_read,
  output logic [DW-1:0] o_icb_cmd_wdata,
  input  logic          o_icb_rsp_valid,
  output logic          o_icb_rsp_ready,
  input  logic [DW-1:0] o_icb_rsp_rdata,
  output logic          timeout_err,
  output logic          busy
);

  localparam int TW = $clog2(TIMEOUT);

  arb_state_t    state;
  logic [TW-1:0] timer;
  logic          last_grant;
  logic          grant;
  logic [1:0]    gnt;
  logic [DW-1:0] rdata_buf;
  logic          tmo_hit;

  uart_rr_arb2 u_pick (
    .req  (m_icb_cmd_valid),
    .last (last_grant),
    .gnt  (gnt)
  );

  assign tmo_hit = (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ARB_IDLE;
      timer          <= '0;
      last_grant     <= 1'b1;
      grant          <= 1'b0;
      rdata_buf      <= '0;
      o_icb_cmd_addr <= '0;
      o_icb_cmd_read <= 1'b0;
      o_icb_cmd_wdata <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          timer <= '0;
          if (gnt != 2'b00) begin
            grant           <= gnt[1];
            o_icb_cmd_addr  <= gnt[1] ? m_icb_cmd_addr[2*AW-1:AW]  : m_icb_cmd_addr[AW-1:0];
            o_icb_cmd_read  <= gnt[1] ? m_icb_cmd_read[1]          : m_icb_cmd_read[0];
            o_icb_cmd_wdata <= gnt[1] ? m_icb_cmd_wdata[2*DW-1:DW] : m_icb_cmd_wdata[DW-1:0];
            state           <= ARB_CMD;
          end
        end
        ARB_CMD: begin
          if (o_icb_cmd_ready) begin
            timer <= '0;
            state <= ARB_WAIT;
          end else if (tmo_hit) begin
            timer     <= '0;
            rdata_buf <= DW'(ARB_ERR_RDATA);
            state     <= ARB_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ARB_WAIT: begin
          // Writes capture too, so the replayed response always carries defined data
          if (o_icb_rsp_valid) begin
            timer     <= '0;
            rdata_buf <= o_icb_rsp_rdata;
            state     <= ARB_RESP;
          end else if (tmo_hit) begin
            timer     <= '0;
            rdata_buf <= DW'(ARB_ERR_RDATA);
            state     <= ARB_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ARB_RESP: begin
          timer <= '0;
          if (m_icb_rsp_ready[grant]) begin
            last_grant <= grant;
            state      <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign m_icb_cmd_ready = (state == ARB_IDLE) ? gnt : 2'b00;
  assign m_icb_rsp_valid = (state == ARB_RESP) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign m_icb_rsp_rdata = (state == ARB_RESP) ? rdata_buf : '0;
  assign o_icb_cmd_valid = (state == ARB_CMD);
  assign o_icb_rsp_ready = (state == ARB_WAIT);
  assign busy            = (state != ARB_IDLE);
  assign timeout_err     = tmo_hit && (((state == ARB_CMD) && !o_icb_cmd_ready) ||
                                       ((state == ARB_WAIT) && !o_icb_rsp_valid));

endmodule
